lscnt_down_n: RTL and testbench
===============================

Name: lscnt_down_n

Overview:
- Parametrised N-bit loadable synchronous down counter with ripple-style active-low borrow chaining.
- Adds three counting modes: free-run wrap, auto-reload and one-shot.
- Provides a reload register and a halt state machine.
- Used for video/timer dividers and DMA length counters; instances cascade via CIL/COL to form wider counters.

Parameters:
- WIDTH, 8, counter width in bits (1..32).
- RST_VAL, 0, value of Q and RELOAD after reset (WIDTH bits).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RSTL  in  1  asynchronous active-low reset.
- D  in  WIDTH  parallel load data.
- LD  in  1  load Q from D (active high).
- LDR  in  1  load RELOAD register from D (active high).
- CIL  in  1  active-low borrow-in/count enable; counter decrements when low.
- MODE  in  2  0 = wrap, 1 = auto-reload, 2 = one-shot, 3 = reserved (treat as wrap).
- Q  out  WIDTH  count value.
- QL  out  WIDTH  bitwise inverse of Q.
- COL  out  1  active-low borrow-out: low iff CIL low and Q == 0 (combinational).
- TC  out  1  registered one-cycle pulse, high the cycle after an underflow event.
- HALTED  out  1  high while in the HALT state.

Behaviour:
- Reset (RSTL low, async):
  - Q = RST_VAL, RELOAD = RST_VAL.
  - TC = 0.
  - State = RUN, so HALTED = 0.
- Underflow event (UF): CIL == 0 and Q == 0 in the state RUN, sampled at the clock edge.
- State machine has two states, RUN and HALT.
- RUN, priority per edge (highest first):
  1. LD: Q <= D; no decrement; TC <= 0.
  2. CIL == 0 and Q != 0: Q <= Q - 1.
  3. UF in mode 0 or 3: Q <= all ones (wrap); TC <= 1.
  4. UF in mode 1: Q <= RELOAD; TC <= 1.
  5. UF in mode 2: Q stays 0; TC <= 1; state -> HALT.
  6. Otherwise: Q holds; TC <= 0.
- HALT:
  - Q holds 0; CIL is ignored; COL is forced high, so no borrow propagates; TC <= 0.
  - LD: Q <= D, state -> RUN, same edge.
  - A MODE change alone does not leave HALT.
- LDR is independent of state and of LD. RELOAD <= D on any edge where LDR is high.
  - If LDR coincides with a mode-1 UF, the reload uses the old RELOAD value (register read before write).
- LD together with UF: LD wins; no TC pulse.
- LD of 0 in one-shot mode: the next enabled edge produces UF and enters HALT.
- Arithmetic is modulo 2^WIDTH. No saturation except the one-shot hold.
- Cascading: feed the low stage's COL into the high stage's CIL; the high stage decrements only when the low stage underflows.
- Latency: Q updates one edge after the qualifying inputs; COL is zero-latency combinational.
- Reset asserted mid-count: the async clear takes effect immediately. Deassertion is treated as synchronous to CLK by the surrounding reset logic.

Optional Feature:
- Macro LSCNT_STICKY_UF_EN. When defined, adds:
  - input UFCLR (1 bit).
  - output UFSTK (1 bit).
- UFSTK behaviour with the macro:
  - set on any UF, cleared by UFCLR; set wins on a simultaneous set and clear.
  - reset value 0.
- Without the macro, neither port exists and no extra flop is inferred.

Decomposition:
- Package lscnt_pkg:
  - enum lscnt_mode_t (WRAP = 0, RELOAD = 1, ONESHOT = 2, RSVD = 3).
  - enum lscnt_state_t (RUN, HALT).
- Natural sub-module lscnt_ctl: the RUN/HALT FSM plus the TC/UFSTK flags. It takes zero-detect, CIL, LD and MODE, and returns the next-value select. The datapath (Q, RELOAD, decrement mux) stays in the top module.

Test Plan:
- Wrap: WIDTH = 4, LD D = 2, CIL = 0, mode 0.
  - Q goes 2, 1, 0, 15, 14.
  - COL is low during the Q = 0 cycle.
  - TC is high in the cycle Q = 15.
- Reload: LDR D = 5, LD D = 1, mode 1, CIL = 0.
  - Q goes 1, 0, 5, 4.
  - TC pulses once.
  - LDR D = 9 on the UF edge: next Q = 5, and the following reload gives 9.
- One-shot: LD D = 3, mode 2, CIL = 0.
  - Q goes 3, 2, 1, 0, 0, 0.
  - HALTED = 1 from the edge after Q reaches 0; COL stays high in HALT.
  - LD D = 7: Q = 7 and HALTED = 0.
- Priority: with Q = 0, CIL = 0 and LD D = 6 on the same edge, Q = 6 and TC = 0.
  - Separately, CIL = 1 holds Q.
- Cascade: two WIDTH = 4 instances chained COL to CIL, loaded 0x10.
  - Sequence 0x10, 0x0F, … 0x00, 0xFF.
- Async reset while counting at Q = 9, RST_VAL = 0: Q = 0 immediately, without a clock edge; TC = 0, HALTED = 0.
- With LSCNT_STICKY_UF_EN defined: UFSTK sets on the first UF and holds until UFCLR is asserted.
  - Simultaneous UF and UFCLR leaves UFSTK = 1.

Source files
------------

// File: rtl/lscnt_pkg.sv
// lscnt_pkg: shared types for the lscnt_down_n loadable down counter.
//   lscnt_mode_t  : counting mode carried on MODE.
//   lscnt_state_t : RUN/HALT control state.
//   lscnt_sel_t   : next-value select handed from lscnt_ctl to the datapath.
// Optional feature macro used by the counter files: LSCNT_STICKY_UF_EN.
package lscnt_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'd0,
        RELOAD  = 2'd1,
        ONESHOT = 2'd2,
        RSVD    = 2'd3
    } lscnt_mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } lscnt_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_LOAD   = 3'd1,
        SEL_DEC    = 3'd2,
        SEL_WRAP   = 3'd3,
        SEL_RELOAD = 3'd4
    } lscnt_sel_t;

endpackage

// File: rtl/lscnt_ctl.sv
// lscnt_ctl: RUN/HALT state machine and underflow flags for lscnt_down_n.
// Decides which value the counter takes on the next edge; the datapath
// itself (Q, RELOAD, decrement) lives in the top module.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   zero       : counter currently equals zero
//   cil        : active-low count enable / borrow-in
//   ld         : parallel load request
//   mode       : counting mode
//   sel        : next-value select for the datapath
//   tc         : registered one-cycle pulse after an underflow
//   halted     : FSM is in HALT
//   ufclr      : clear for the sticky flag (LSCNT_STICKY_UF_EN only)
//   ufstk      : sticky underflow flag      (LSCNT_STICKY_UF_EN only)
module lscnt_ctl
    import lscnt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        zero,
    input  logic        cil,
    input  logic        ld,
    input  lscnt_mode_t mode,
`ifdef LSCNT_STICKY_UF_EN
    input  logic        ufclr,
    output logic        ufstk,
`endif
    output lscnt_sel_t  sel,
    output logic        tc,
    output logic        halted
);

    lscnt_state_t state;
    lscnt_state_t state_nxt;
    logic         uf;
    logic         tc_nxt;

    // Underflow only exists in RUN: HALT ignores the borrow-in entirely.
    assign uf     = (state == RUN) && !cil && zero;
    assign halted = (state == HALT);

    always_comb begin
        state_nxt = state;
        sel       = SEL_HOLD;
        if (state == HALT) begin
            if (ld) begin
                sel       = SEL_LOAD;
                state_nxt = RUN;
            end
        end else if (ld) begin
            sel = SEL_LOAD;
        end else if (!cil && !zero) begin
            sel = SEL_DEC;
        end else if (uf) begin
            case (mode)
                RELOAD:  sel = SEL_RELOAD;
                ONESHOT: begin
                    // Q already sits at zero, holding it is the one-shot stop.
                    sel       = SEL_HOLD;
                    state_nxt = HALT;
                end
                default: sel = SEL_WRAP;
            endcase
        end
    end

    // A load on the underflow edge suppresses the terminal-count pulse.
    assign tc_nxt = uf && !ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            tc    <= tc_nxt;
        end
    end

`ifdef LSCNT_STICKY_UF_EN
    // Set has priority over clear so an underflow is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ufstk <= 1'b0;
        end else if (uf) begin
            ufstk <= 1'b1;
        end else if (ufclr) begin
            ufstk <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/lscnt_down_n.sv
// lscnt_down_n: WIDTH-bit loadable synchronous down counter with active-low
// borrow chaining (COL of a low stage feeds CIL of the next stage), three
// counting modes (wrap, auto-reload, one-shot), a reload register and a
// RUN/HALT state machine.
// Optional feature macro: LSCNT_STICKY_UF_EN adds UFCLR/UFSTK.
// Ports:
//   CLK    : clock, rising edge
//   RSTL   : asynchronous active-low reset
//   D      : parallel data for Q (LD) and RELOAD (LDR)
//   LD     : load Q from D
//   LDR    : load RELOAD from D
//   CIL    : active-low borrow-in / count enable
//   MODE   : 0 wrap, 1 auto-reload, 2 one-shot, 3 behaves as wrap
//   Q, QL  : count value and its bitwise inverse
//   COL    : active-low borrow-out, combinational
//   TC     : one-cycle pulse the cycle after an underflow
//   HALTED : one-shot has stopped
//   UFCLR  : clear sticky underflow flag (optional)
//   UFSTK  : sticky underflow flag       (optional)
module lscnt_down_n
    import lscnt_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RSTL,
    input  logic [WIDTH-1:0] D,
    input  logic             LD,
    input  logic             LDR,
    input  logic             CIL,
    input  logic [1:0]       MODE,
`ifdef LSCNT_STICKY_UF_EN
    input  logic             UFCLR,
    output logic             UFSTK,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QL,
    output logic             COL,
    output logic             TC,
    output logic             HALTED
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload;
    logic             zero;
    lscnt_sel_t       sel;

    assign zero = (count == '0);

    lscnt_ctl u_ctl (
        .clk    (CLK),
        .rst_n  (RSTL),
        .zero   (zero),
        .cil    (CIL),
        .ld     (LD),
        .mode   (lscnt_mode_t'(MODE)),
`ifdef LSCNT_STICKY_UF_EN
        .ufclr  (UFCLR),
        .ufstk  (UFSTK),
`endif
        .sel    (sel),
        .tc     (TC),
        .halted (HALTED)
    );

    always_comb begin
        count_nxt = count;
        case (sel)
            SEL_LOAD:   count_nxt = D;
            SEL_DEC:    count_nxt = count - WIDTH'(1);
            SEL_WRAP:   count_nxt = '1;
            // Reads the pre-edge reload value, so an LDR on the same edge
            // only affects the next reload.
            SEL_RELOAD: count_nxt = reload;
            default:    count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            count  <= RST_VAL;
            reload <= RST_VAL;
        end else begin
            count <= count_nxt;
            if (LDR) begin
                reload <= D;
            end
        end
    end

    assign Q  = count;
    assign QL = ~count;
    // Borrow-out is suppressed in HALT so a stopped one-shot never
    // decrements the stage above it.
    assign COL = !(!CIL && zero && !HALTED);

endmodule

// File: tb/tb_lscnt_down_n.sv
// Randomized self-checking bench for lscnt_down_n (WIDTH = 4) against a
// behavioural reference model, plus a two-stage cascade and an async reset.
module tb_lscnt_down_n;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] d;
    logic         ld, ldr, cil;
    logic [1:0]   mode;
    logic [W-1:0] q, ql;
    logic         col, tc, halted;

    // cascade: lo stage COL drives hi stage CIL
    logic [W-1:0] c_dlo, c_dhi;
    logic         c_ld, c_cil;
    logic [W-1:0] c_qlo, c_qhi, c_qllo, c_qlhi;
    logic         c_lo_col, c_hi_col, c_lo_tc, c_hi_tc, c_lo_h, c_hi_h;

`ifdef LSCNT_STICKY_UF_EN
    logic ufclr;
    logic ufstk, c_lo_stk, c_hi_stk;
    bit   uc;
    bit   m_stk;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_q, m_reload, c_val;
    bit m_halt, m_tc;

    always #5 clk = ~clk;

    lscnt_down_n #(.WIDTH(W), .RST_VAL(4'd0)) u_dut (
        .CLK(clk), .RSTL(rst_n), .D(d), .LD(ld), .LDR(ldr), .CIL(cil), .MODE(mode),
`ifdef LSCNT_STICKY_UF_EN
        .UFCLR(ufclr), .UFSTK(ufstk),
`endif
        .Q(q), .QL(ql), .COL(col), .TC(tc), .HALTED(halted)
    );

    lscnt_down_n #(.WIDTH(W)) u_lo (
        .CLK(clk), .RSTL(rst_n), .D(c_dlo), .LD(c_ld), .LDR(1'b0), .CIL(c_cil), .MODE(2'd0),
`ifdef LSCNT_STICKY_UF_EN
        .UFCLR(1'b0), .UFSTK(c_lo_stk),
`endif
        .Q(c_qlo), .QL(c_qllo), .COL(c_lo_col), .TC(c_lo_tc), .HALTED(c_lo_h)
    );

    lscnt_down_n #(.WIDTH(W)) u_hi (
        .CLK(clk), .RSTL(rst_n), .D(c_dhi), .LD(c_ld), .LDR(1'b0), .CIL(c_lo_col), .MODE(2'd0),
`ifdef LSCNT_STICKY_UF_EN
        .UFCLR(1'b0), .UFSTK(c_hi_stk),
`endif
        .Q(c_qhi), .QL(c_qlhi), .COL(c_hi_col), .TC(c_hi_tc), .HALTED(c_hi_h)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_reload = 0; m_halt = 0; m_tc = 0;
`ifdef LSCNT_STICKY_UF_EN
        m_stk = 0;
`endif
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".q"},      int'(q),      m_q);
        chk({tag, ".ql"},     int'(ql),     MAXV - m_q);
        chk({tag, ".tc"},     int'(tc),     int'(m_tc));
        chk({tag, ".halted"}, int'(halted), int'(m_halt));
`ifdef LSCNT_STICKY_UF_EN
        chk({tag, ".ufstk"},  int'(ufstk),  int'(m_stk));
`endif
    endtask

    // One clock of the main DUT: drive at negedge, check COL combinationally,
    // advance the model at the edge, check the registered outputs after it.
    task automatic step(input string tag, input bit ld_v, input int d_v, input bit ldr_v,
                        input bit cil_v, input int mode_v);
        bit uf;
        @(negedge clk);
        ld = ld_v; d = W'(d_v); ldr = ldr_v; cil = cil_v; mode = 2'(mode_v);
`ifdef LSCNT_STICKY_UF_EN
        ufclr = uc;
`endif
        #1;
        chk({tag, ".col"}, int'(col), (!m_halt && !cil_v && m_q == 0) ? 0 : 1);
        @(posedge clk);
        uf   = !m_halt && !cil_v && (m_q == 0);
        m_tc = 0;
        if (ld_v) begin
            m_q    = d_v;
            m_halt = 0;
        end else if (!m_halt && !cil_v) begin
            if (m_q != 0) begin
                m_q = m_q - 1;
            end else begin
                m_tc = 1;
                if (mode_v == 1)      m_q = m_reload;
                else if (mode_v == 2) m_halt = 1;
                else                  m_q = MAXV;
            end
        end
        if (ldr_v) m_reload = d_v;
`ifdef LSCNT_STICKY_UF_EN
        if (uf) m_stk = 1;
        else if (uc) m_stk = 0;
`else
        if (uf) m_tc = m_tc;
`endif
        #1;
        check_regs(tag);
    endtask

    task automatic cstep(input bit ld_v, input int val);
        int prev;
        @(negedge clk);
        c_ld = ld_v; c_dlo = val[3:0]; c_dhi = val[7:4]; c_cil = 1'b0;
        #1;
        chk("c_col", int'(c_hi_col), (c_val == 0) ? 0 : 1);
        @(posedge clk);
        prev  = c_val;
        c_val = ld_v ? val : ((c_val - 1) & 255);
        #1;
        chk("c_q",     int'({c_qhi, c_qlo}),   c_val);
        chk("c_ql",    int'({c_qlhi, c_qllo}), 255 - c_val);
        chk("c_lo_tc", int'(c_lo_tc), (!ld_v && (prev & 15) == 0) ? 1 : 0);
        chk("c_hi_tc", int'(c_hi_tc), (!ld_v && prev == 0) ? 1 : 0);
        chk("c_halt",  int'({c_hi_h, c_lo_h}), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ld = 0; ldr = 0; cil = 1; d = '0; mode = '0;
        c_ld = 0; c_cil = 1; c_dlo = '0; c_dhi = '0;
`ifdef LSCNT_STICKY_UF_EN
        ufclr = 0; uc = 0;
`endif
        model_reset();
        c_val = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_regs("reset");

        // wrap, mode 0: 2,1,0,15,14
        step("wrap_ld", 1, 2, 0, 0, 0);
        step("wrap", 0, 0, 0, 0, 0);
        step("wrap", 0, 0, 0, 0, 0);
        step("wrap_uf", 0, 0, 0, 0, 0);
        chk("wrap_15", int'(q), 15);
        chk("wrap_tc", int'(tc), 1);
        step("wrap", 0, 0, 0, 0, 0);
        chk("wrap_14", int'(q), 14);

        // auto-reload, including LDR coinciding with the underflow edge
        step("rl_ldr", 0, 5, 1, 1, 1);
        step("rl_ld", 1, 1, 0, 0, 1);
        step("rl", 0, 0, 0, 0, 1);
        step("rl_uf", 0, 0, 0, 0, 1);
        chk("rl_5", int'(q), 5);
        step("rl", 0, 0, 0, 0, 1);
        chk("rl_4", int'(q), 4);
        step("rl_ld0", 1, 0, 0, 0, 1);
        step("rl_uf_ldr", 0, 9, 1, 0, 1);
        chk("rl_old", int'(q), 5);
        repeat (5) step("rl", 0, 0, 0, 0, 1);
        step("rl_uf2", 0, 0, 0, 0, 1);
        chk("rl_new", int'(q), 9);

        // one-shot
        step("os_ld", 1, 3, 0, 0, 2);
        repeat (3) step("os", 0, 0, 0, 0, 2);
        chk("os_zero", int'(q), 0);
        step("os_uf", 0, 0, 0, 0, 2);
        chk("os_halt", int'(halted), 1);
        step("os_hold", 0, 0, 0, 0, 2);
        step("os_mode", 0, 0, 0, 0, 0);
        chk("os_still", int'(halted), 1);
        step("os_reld", 1, 7, 0, 0, 2);
        chk("os_run", int'({halted, q}), 7);

        // priority: LD beats underflow; CIL high holds
        step("pr_ld0", 1, 0, 0, 1, 0);
        step("pr_ld", 1, 6, 0, 0, 0);
        chk("pr_q6tc0", int'({tc, q}), 6);
        step("pr_hold", 0, 0, 0, 1, 0);
        chk("pr_hold6", int'(q), 6);

`ifdef LSCNT_STICKY_UF_EN
        // sticky flag: set, hold, clear, set-beats-clear
        step("st_ld0", 1, 0, 0, 1, 0);
        step("st_uf", 0, 0, 0, 0, 0);
        step("st_hold", 0, 0, 0, 1, 0);
        chk("st_set", int'(ufstk), 1);
        uc = 1;
        step("st_clr", 0, 0, 0, 1, 0);
        step("st_ld0b", 1, 0, 0, 1, 0);
        step("st_both", 0, 0, 0, 0, 0);
        chk("st_both1", int'(ufstk), 1);
        uc = 0;
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
`ifdef LSCNT_STICKY_UF_EN
            uc = ($urandom_range(0, 7) == 0);
`endif
            step("rnd", ($urandom_range(0, 7) == 0), int'($urandom_range(0, MAXV)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 3)));
        end

        // async reset mid-count at Q = 9
        step("ar_ld", 1, 10, 0, 0, 0);
        step("ar_9", 0, 0, 0, 0, 0);
        chk("ar_pre", int'(q), 9);
        @(negedge clk);
        ld = 0; ldr = 0; cil = 0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("ar_now");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_regs("ar_rel");

        // cascade: load 0x10 and count through 0x00 to 0xFF
        cstep(1, 8'h10);
        for (int i = 0; i < 18; i++) cstep(0, 0);
        chk("c_end", int'({c_qhi, c_qlo}), 8'hFE);
`ifdef LSCNT_STICKY_UF_EN
        chk("c_stk", int'({c_hi_stk, c_lo_stk}), 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
